uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Sequencing controller for the UART receive datapath. It oversamples the serial line on a baud tick, validates the start bit and generates the one-cycle `shift`, `parity_load` and `check_stop` strobes that drive the shift register, parity checker and stop-bit checker at mid-bit. It latches the checker results with each completed frame and presents them to the consumer through a valid/ready handshake with overrun detection.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame (≥5).
- `OVERSAMPLE`, default 16: baud ticks per bit (even, ≥4).

- `rx_clk` input, 1 bit: receive clock.
- `rx_rst_n` input, 1 bit: reset, asynchronous, active-low.
- `baud_tick` input, 1 bit: one-`rx_clk` pulse at OVERSAMPLE × baud.
- `rx_in` input, 1 bit: raw serial line, idle high.
- `parity_bit_error` input, 1 bit: parity checker result.
- `stop_bit_error` input, 1 bit: stop-bit checker result.
- `rx_ready` input, 1 bit: consumer accepts the frame.
- `shift` output, 1 bit: strobe that shifts one data bit into the shift register.
- `parity_load` output, 1 bit: strobe that evaluates parity.
- `check_stop` output, 1 bit: strobe that evaluates the stop bit.
- `rx_valid` output, 1 bit: a frame is available.
- `parity_error` output, 1 bit: parity error of the presented frame.
- `frame_error` output, 1 bit: stop-bit error of the presented frame.
- `overrun` output, 1 bit: sticky flag; a frame was lost.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- `rx_in` passes through a 2-flop synchronizer (reset value 1). All logic below uses the synchronized value `rxs`.
- Sample counter `scnt` is $clog2(OVERSAMPLE) bits wide and advances only on `baud_tick`. Bit counter `bcnt` is $clog2(DATA_WIDTH+1) bits wide.
- States:
  - IDLE: a 1→0 transition of `rxs` moves to START and clears `scnt`.
  - START: on the tick where `scnt`==OVERSAMPLE/2−1:
    - `rxs`==0 → DATA; `scnt` and `bcnt` clear.
    - `rxs`==1 → IDLE (false start, no strobe, no flag).
  - DATA: on the tick where `scnt`==OVERSAMPLE−1, pulse `shift` and increment `bcnt`; `scnt` wraps to 0. After the DATA_WIDTH-th shift, go to PARITY (or STOP, see Configuration).
  - PARITY: on the tick where `scnt`==OVERSAMPLE−1, pulse `parity_load` and go to STOP.
  - STOP: on the tick where `scnt`==OVERSAMPLE−1, pulse `check_stop` and go to DONE.
  - DONE: lasts one cycle. Capture `parity_bit_error` into `parity_error` and `stop_bit_error` into `frame_error`, set `rx_valid`, return to IDLE.
- Every strobe is exactly one `rx_clk` wide and is coincident with `baud_tick`.
- Handshake: a transfer occurs on a cycle with `rx_valid`&&`rx_ready`. `rx_valid` and the error flags hold until the transfer.
- Overrun: DONE with `rx_valid`=1 and no transfer in that cycle sets `overrun`. The new error flags overwrite the old ones and `rx_valid` stays 1.
- If DONE coincides with a transfer, the old frame is accepted, `rx_valid` stays 1 with the new flags, and `overrun` is not set.
- `overrun` clears on the next transfer that is not coincident with DONE.
- IDLE detects a new start edge immediately after DONE; the remaining half of the stop bit is high, so no false edge occurs.

## Timing
- Reset (asynchronous, any state, including mid-frame): state=IDLE, counters=0, all outputs 0, synchronizer=1. The frame in progress is discarded.
- Line-to-logic latency is 2 `rx_clk` cycles.
- The START check falls OVERSAMPLE/2 ticks after edge detection. Each later strobe falls OVERSAMPLE ticks after the previous one.
- `rx_valid` rises 2 `rx_clk` cycles after the `check_stop` pulse: one cycle in DONE, with the register update visible the next cycle.
- The checker inputs are sampled in the DONE cycle, which is 1 cycle after their strobe. The checkers must hold their results until then.
- A `baud_tick` in DONE or IDLE does not advance `scnt`.

## Configuration
- `UART_RX_CTRL_PARITY_EN` defined: the PARITY state exists as above, and `parity_error` reflects `parity_bit_error`.
- Not defined: DATA goes directly to STOP after the last shift. `parity_load` and `parity_error` are tied to 0, and the frame is one bit shorter.

## Test plan
- Reset mid-DATA after 3 shifts → all outputs 0 next cycle; a fresh 0x55 frame is then received normally.
- Frame 0xA5, even parity, OVERSAMPLE=16, with `rx_ready` held at 1:
  - exactly 8 `shift` pulses spaced 16 ticks apart, the first 24 ticks after the falling edge;
  - one `parity_load`, then one `check_stop`;
  - `rx_valid` asserted for 1 cycle with `parity_error`=0 and `frame_error`=0.
- 5-tick low glitch on `rx_in` → return to IDLE with no strobes, `rx_valid`=0 and `busy` low again.
- `stop_bit_error`=1 driven at the `check_stop` pulse, with `parity_bit_error`=1 at the `parity_load` pulse → `frame_error`=1 and `parity_error`=1 with `rx_valid`.
- Two back-to-back frames with `rx_ready`=0:
  - `overrun`=1 after the second DONE;
  - a single `rx_ready` pulse then clears both `rx_valid` and `overrun`.
- Build without `UART_RX_CTRL_PARITY_EN` → `check_stop` falls 16 ticks after the 8th `shift`; `parity_load` is never asserted.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit validation, mid-bit strobes, frame result handshake.
// Optional parity stage enabled by defining UART_RX_CTRL_PARITY_EN.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic rx_clk,
    input  logic rx_rst_n,
    input  logic baud_tick,
    input  logic rx_in,
    input  logic parity_bit_error,
    input  logic stop_bit_error,
    input  logic rx_ready,
    output logic shift,
    output logic parity_load,
    output logic check_stop,
    output logic rx_valid,
    output logic parity_error,
    output logic frame_error,
    output logic overrun,
    output logic busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   scnt, scnt_nxt;
    logic [BW-1:0]   bcnt, bcnt_nxt;
    logic            sync1, rxs, rxs_q;

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_q <= 1'b1;
            state <= IDLE;
            scnt  <= '0;
            bcnt  <= '0;
        end else begin
            sync1 <= rx_in;
            rxs   <= sync1;
            rxs_q <= rxs;
            state <= state_nxt;
            scnt  <= scnt_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        scnt_nxt    = scnt;
        bcnt_nxt    = bcnt;
        shift       = 1'b0;
        parity_load = 1'b0;
        check_stop  = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_q && !rxs) begin
                    state_nxt = START;
                    scnt_nxt  = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (scnt == S_HALF) begin
                        if (rxs) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DATA;
                            scnt_nxt  = '0;
                            bcnt_nxt  = '0;
                        end
                    end else begin
                        scnt_nxt = scnt + SW'(1);
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (scnt == S_LAST) begin
                        shift    = 1'b1;
                        scnt_nxt = '0;
                        bcnt_nxt = bcnt + BW'(1);
                        if (bcnt == B_LAST) begin
`ifdef UART_RX_CTRL_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end
                    end else begin
                        scnt_nxt = scnt + SW'(1);
                    end
                end
            end
`ifdef UART_RX_CTRL_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    if (scnt == S_LAST) begin
                        parity_load = 1'b1;
                        scnt_nxt    = '0;
                        state_nxt   = STOP;
                    end else begin
                        scnt_nxt = scnt + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    if (scnt == S_LAST) begin
                        check_stop = 1'b1;
                        scnt_nxt   = '0;
                        state_nxt  = DONE;
                    end else begin
                        scnt_nxt = scnt + SW'(1);
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // A DONE that coincides with a transfer replaces the accepted frame; overrun is left as is.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else if (state == DONE) begin
            rx_valid    <= 1'b1;
            frame_error <= stop_bit_error;
            if (rx_valid && !rx_ready) overrun <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

`ifdef UART_RX_CTRL_PARITY_EN
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n)           parity_error <= 1'b0;
        else if (state == DONE)  parity_error <= parity_bit_error;
    end
`else
    logic unused_parity_in;
    assign unused_parity_in = parity_bit_error;
    assign parity_error     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: tick-count frame model checked every cycle plus literal frame checks.
module tb_uart_rx_ctrl;

    localparam int DW    = 8;
    localparam int OS    = 16;
    localparam int HALF  = OS / 2;
    localparam int TP    = 3;
    localparam int BITC  = OS * TP;
`ifdef UART_RX_CTRL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = DW + PAR + 1;

    logic clk = 1'b0, rst_n = 1'b0, baud_tick = 1'b0, rx_in = 1'b1;
    logic pbe = 1'b0, sbe = 1'b0, rx_ready = 1'b0, abort = 1'b0;
    logic shift, parity_load, check_stop, rx_valid, parity_error, frame_error, overrun, busy;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .rx_clk(clk), .rx_rst_n(rst_n), .baud_tick(baud_tick), .rx_in(rx_in),
        .parity_bit_error(pbe), .stop_bit_error(sbe), .rx_ready(rx_ready),
        .shift(shift), .parity_load(parity_load), .check_stop(check_stop),
        .rx_valid(rx_valid), .parity_error(parity_error), .frame_error(frame_error),
        .overrun(overrun), .busy(busy)
    );

    initial begin
        int tc;
        tc = 0;
        forever begin
            @(posedge clk); #1;
            baud_tick = (tc == TP - 1);
            tc = (tc + 1) % TP;
        end
    end

    int n_cmp = 0, n_fail = 0, cyc = 0;
    string req_name = "";
    int req_act = 0, req_exp = 0, req_seq = 0, ack_seq = 0;

    // Model: position within a frame measured in baud ticks since edge detection.
    bit m_s1 = 1, m_s2 = 1, m_s3 = 1, m_active = 0, m_done = 0;
    bit m_valid = 0, m_pe = 0, m_fe = 0, m_ov = 0;
    int m_k = 0;

    int tick_total = 0, t_last = 0, first_gap = 0, gmin = 0, gmax = 0;
    int cs_cyc = 0, valid_delay = 0, vcnt = 0, n_sh = 0, n_pl = 0, n_cs = 0;
    bit busy_q = 0, valid_q = 0, first = 0;
    int lat_pe = 0, lat_fe = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit e_sh, e_pl, e_cs, was_done;
        int kn, j, g;
        e_sh = 0; e_pl = 0; e_cs = 0;
        kn = m_k + 1;
        cyc++;
        if (req_seq != ack_seq) begin
            chk(req_name, req_act, req_exp);
            ack_seq = req_seq;
        end
        if (!rst_n) begin
            m_s1 = 1; m_s2 = 1; m_s3 = 1; m_active = 0; m_done = 0;
            m_valid = 0; m_pe = 0; m_fe = 0; m_ov = 0; m_k = 0;
        end else if (m_active && baud_tick && kn >= HALF && (kn - HALF) % OS == 0) begin
            j = (kn - HALF) / OS;
            if (j >= 1 && j <= DW)              e_sh = 1;
            else if (PAR != 0 && j == DW + 1)   e_pl = 1;
            else if (j == NBITS)                e_cs = 1;
        end
        chk("shift", shift, e_sh);
        chk("parity_load", parity_load, e_pl);
        chk("check_stop", check_stop, e_cs);
        chk("busy", busy, m_active || m_done);
        chk("rx_valid", rx_valid, m_valid);
        chk("parity_error", parity_error, m_pe);
        chk("frame_error", frame_error, m_fe);
        chk("overrun", overrun, m_ov);
        if (rst_n) begin
            was_done = m_done;
            if (m_done) begin
                if (m_valid && !rx_ready) m_ov = 1;
                m_valid = 1;
                m_pe = (PAR != 0) ? pbe : 1'b0;
                m_fe = sbe;
                m_done = 0;
            end else if (m_valid && rx_ready) begin
                m_valid = 0;
                m_ov = 0;
            end
            if (m_active) begin
                if (baud_tick) begin
                    if (kn == HALF && m_s2)                 m_active = 0;
                    else if (kn == HALF + NBITS * OS) begin m_active = 0; m_done = 1; end
                    else                                    m_k = kn;
                end
            end else if (!was_done && m_s3 && !m_s2) begin
                m_active = 1;
                m_k = 0;
            end
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = rx_in;
        end

        if (busy && !busy_q) begin
            t_last = tick_total; first = 1; gmin = 1 << 30; gmax = 0;
        end
        if (baud_tick) tick_total++;
        if (shift || parity_load || check_stop) begin
            g = tick_total - t_last;
            t_last = tick_total;
            if (first) begin first_gap = g; first = 0; end
            else begin
                if (g < gmin) gmin = g;
                if (g > gmax) gmax = g;
            end
        end
        if (shift)       n_sh++;
        if (parity_load) n_pl++;
        if (check_stop)  begin n_cs++; cs_cyc = cyc; end
        if (rx_valid && !valid_q) begin
            valid_delay = cyc - cs_cyc; lat_pe = parity_error; lat_fe = frame_error;
        end
        if (rx_valid) vcnt++;
        busy_q = busy; valid_q = rx_valid;
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        req_name = name; req_act = act; req_exp = exp; req_seq++;
        @(negedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [7:0] d);
        logic [11:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < DW; i++) b[1 + i] = d[i];
        if (PAR != 0) b[DW + 1] = ^d;
        for (int i = 0; i < NBITS + 1; i++) begin
            rx_in = b[i];
            for (int c = 0; c < BITC; c++) begin
                @(posedge clk); #1;
                if (abort) begin rx_in = 1'b1; return; end
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic frame_checks(input string tag, input int sh0, input int pl0, input int cs0);
        lit({tag, "_shifts"}, n_sh - sh0, DW);
        lit({tag, "_parity_loads"}, n_pl - pl0, PAR);
        lit({tag, "_check_stops"}, n_cs - cs0, 1);
        lit({tag, "_first_shift_ticks"}, first_gap, HALF + OS);
        lit({tag, "_min_gap"}, gmin, OS);
        lit({tag, "_max_gap"}, gmax, OS);
        lit({tag, "_valid_delay"}, valid_delay, 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sh0, pl0, cs0, v0, got;
        cycles(3);
        rst_n = 1'b1;
        cycles(20);
        lit("reset_valid", rx_valid, 0);
        lit("reset_busy", busy, 0);
        lit("reset_overrun", overrun, 0);

        sh0 = n_sh; got = 0;
        fork
            send_frame(8'h33);
            begin
                for (int i = 0; i < 4000 && got == 0; i++) begin
                    cycles(1);
                    if (n_sh - sh0 >= 3) got = 1;
                end
                rst_n = 1'b0;
                abort = 1'b1;
            end
        join
        lit("rst_wait_3_shifts", got, 1);
        lit("rst_shifts_seen", n_sh - sh0, 3);
        lit("rst_busy", busy, 0);
        lit("rst_shift", shift, 0);
        cycles(4);
        abort = 1'b0;
        rst_n = 1'b1;
        cycles(20);

        rx_ready = 1'b1;
        sh0 = n_sh; pl0 = n_pl; cs0 = n_cs; v0 = vcnt;
        send_frame(8'h55);
        cycles(10);
        frame_checks("f55", sh0, pl0, cs0);

        sh0 = n_sh; pl0 = n_pl; cs0 = n_cs; v0 = vcnt;
        send_frame(8'hA5);
        cycles(10);
        frame_checks("fa5", sh0, pl0, cs0);
        lit("fa5_valid_cycles", vcnt - v0, 1);
        lit("fa5_parity_error", lat_pe, 0);
        lit("fa5_frame_error", lat_fe, 0);

        sh0 = n_sh; pl0 = n_pl; cs0 = n_cs; v0 = vcnt;
        rx_in = 1'b0;
        cycles(5 * TP);
        rx_in = 1'b1;
        cycles(100);
        lit("glitch_shifts", n_sh - sh0, 0);
        lit("glitch_parity_loads", n_pl - pl0, 0);
        lit("glitch_check_stops", n_cs - cs0, 0);
        lit("glitch_valid_cycles", vcnt - v0, 0);
        lit("glitch_busy", busy, 0);

        sh0 = n_sh; pl0 = n_pl; cs0 = n_cs;
        pbe = 1'b1; sbe = 1'b1;
        send_frame(8'h0F);
        cycles(10);
        pbe = 1'b0; sbe = 1'b0;
        frame_checks("ferr", sh0, pl0, cs0);
        lit("ferr_parity_error", lat_pe, PAR);
        lit("ferr_frame_error", lat_fe, 1);

        rx_ready = 1'b0;
        send_frame(8'h12);
        send_frame(8'h34);
        cycles(10);
        lit("ovr_overrun_set", overrun, 1);
        lit("ovr_valid_held", rx_valid, 1);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        cycles(2);
        lit("ovr_valid_cleared", rx_valid, 0);
        lit("ovr_overrun_cleared", overrun, 0);
        cycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
